// File: rtl/reg_file_pkg.sv
// Shared constants and types for the architectural register file slice.
// Optional same-cycle commit bypass is enabled by COMMIT_BYPASS_EN.
package reg_file_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int ROBWD     = 32;
    localparam int ROBSZ     = 16;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;

    // x0 is hardwired: never renamed, written or reported busy.
    function automatic logic is_live(input reg_idx_t r);
        return r != X0;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decoder/ROB facing bundle of the register file: rename, read,
// commit and flush signals. master = decoder/ROB, slave = reg_file.
interface reg_file_if #(
    parameter int TAGW = 32
);
    import reg_file_pkg::*;

    logic            jump_wrong_flag;
    logic            ID_rename_flag;
    reg_idx_t        ID_rename_rd;
    logic [TAGW-1:0] ID_rename_rob_id;
    reg_idx_t        ID_rs1;
    reg_idx_t        ID_rs2;
    logic            RF_rs1_busy;
    logic [TAGW-1:0] RF_rs1_rob_id;
    logic [XLEN-1:0] RF_rs1_val;
    logic            RF_rs2_busy;
    logic [TAGW-1:0] RF_rs2_rob_id;
    logic [XLEN-1:0] RF_rs2_val;
    logic            cmt_flag;
    reg_idx_t        cmt_rd;
    logic [TAGW-1:0] cmt_rob_id;
    logic [XLEN-1:0] cmt_val;

    modport master (
        output jump_wrong_flag,
        output ID_rename_flag,
        output ID_rename_rd,
        output ID_rename_rob_id,
        output ID_rs1,
        output ID_rs2,
        input  RF_rs1_busy,
        input  RF_rs1_rob_id,
        input  RF_rs1_val,
        input  RF_rs2_busy,
        input  RF_rs2_rob_id,
        input  RF_rs2_val,
        output cmt_flag,
        output cmt_rd,
        output cmt_rob_id,
        output cmt_val
    );

    modport slave (
        input  jump_wrong_flag,
        input  ID_rename_flag,
        input  ID_rename_rd,
        input  ID_rename_rob_id,
        input  ID_rs1,
        input  ID_rs2,
        output RF_rs1_busy,
        output RF_rs1_rob_id,
        output RF_rs1_val,
        output RF_rs2_busy,
        output RF_rs2_rob_id,
        output RF_rs2_val,
        input  cmt_flag,
        input  cmt_rd,
        input  cmt_rob_id,
        input  cmt_val
    );

endinterface

// File: rtl/reg_file_rf_read_port.sv
// One combinational register-file read port, with optional forwarding
// of a matching same-cycle commit (COMMIT_BYPASS_EN).
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int TAGW = 32
) (
    input  reg_idx_t        rs,
    input  logic            reg_busy,
    input  logic [TAGW-1:0] reg_tag,
    input  logic [XLEN-1:0] reg_val,
`ifdef COMMIT_BYPASS_EN
    input  logic            cmt_flag,
    input  reg_idx_t        cmt_rd,
    input  logic [TAGW-1:0] cmt_rob_id,
    input  logic [XLEN-1:0] cmt_val,
`endif
    output logic            busy,
    output logic [TAGW-1:0] rob_id,
    output logic [XLEN-1:0] val
);

    logic live;

`ifdef COMMIT_BYPASS_EN
    logic hit;

    // Only the current producer's commit may release the operand.
    assign hit = live && cmt_flag && (cmt_rd == rs)
              && reg_busy && (reg_tag == cmt_rob_id);
`endif

    assign live = is_live(rs);

    always_comb begin
        busy   = live & reg_busy;
        rob_id = busy ? reg_tag : '0;
        val    = live ? reg_val : '0;
`ifdef COMMIT_BYPASS_EN
        if (hit) begin
            busy   = FALSE;
            rob_id = '0;
            val    = cmt_val;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file plus rename-tag table behind the ROB.
// Build with COMMIT_BYPASS_EN to forward same-cycle commits to reads.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int NREG = 32,
    parameter int TAGW = 32
) (
    input logic         clk,
    input logic         rst,
    input logic         rdy,
    reg_file_if.slave   bus
);

    logic [XLEN-1:0] val_q  [NREG];
    logic [TAGW-1:0] tag_q  [NREG];
    logic            busy_q [NREG];

    logic do_cmt;
    logic do_ren;
    logic cmt_rel;

    assign do_cmt = bus.cmt_flag && is_live(bus.cmt_rd);
    assign do_ren = bus.ID_rename_flag
                 && is_live(bus.ID_rename_rd)
                 && !bus.jump_wrong_flag;

    // Release only if the committing inst is still the latest producer.
    assign cmt_rel = busy_q[bus.cmt_rd]
                  && (tag_q[bus.cmt_rd] == bus.cmt_rob_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i]  <= '0;
                tag_q[i]  <= '0;
                busy_q[i] <= FALSE;
            end
        end else if (rdy) begin
            if (do_cmt) begin
                val_q[bus.cmt_rd] <= bus.cmt_val;
                if (cmt_rel)
                    busy_q[bus.cmt_rd] <= FALSE;
            end
            if (do_ren) begin
                busy_q[bus.ID_rename_rd] <= TRUE;
                tag_q[bus.ID_rename_rd]  <= bus.ID_rename_rob_id;
            end
            if (bus.jump_wrong_flag) begin
                for (int i = 0; i < NREG; i++)
                    busy_q[i] <= FALSE;
            end
        end
    end

    rf_read_port #(.TAGW(TAGW)) u_rs1 (
        .rs         (bus.ID_rs1),
        .reg_busy   (busy_q[bus.ID_rs1]),
        .reg_tag    (tag_q[bus.ID_rs1]),
        .reg_val    (val_q[bus.ID_rs1]),
`ifdef COMMIT_BYPASS_EN
        .cmt_flag   (bus.cmt_flag),
        .cmt_rd     (bus.cmt_rd),
        .cmt_rob_id (bus.cmt_rob_id),
        .cmt_val    (bus.cmt_val),
`endif
        .busy       (bus.RF_rs1_busy),
        .rob_id     (bus.RF_rs1_rob_id),
        .val        (bus.RF_rs1_val)
    );

    rf_read_port #(.TAGW(TAGW)) u_rs2 (
        .rs         (bus.ID_rs2),
        .reg_busy   (busy_q[bus.ID_rs2]),
        .reg_tag    (tag_q[bus.ID_rs2]),
        .reg_val    (val_q[bus.ID_rs2]),
`ifdef COMMIT_BYPASS_EN
        .cmt_flag   (bus.cmt_flag),
        .cmt_rd     (bus.cmt_rd),
        .cmt_rob_id (bus.cmt_rob_id),
        .cmt_val    (bus.cmt_val),
`endif
        .busy       (bus.RF_rs2_busy),
        .rob_id     (bus.RF_rs2_rob_id),
        .val        (bus.RF_rs2_val)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Expectations follow COMMIT_BYPASS_EN when it is defined.
module tb_reg_file;

    logic clk;
    logic rst;
    logic rdy;

    int n_chk  = 0;
    int n_fail = 0;

    reg_file_if #(.TAGW(32)) bus ();

    reg_file #(.NREG(32), .TAGW(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.jump_wrong_flag  = 1'b0;
        bus.ID_rename_flag   = 1'b0;
        bus.ID_rename_rd     = '0;
        bus.ID_rename_rob_id = '0;
        bus.cmt_flag         = 1'b0;
        bus.cmt_rd           = '0;
        bus.cmt_rob_id       = '0;
        bus.cmt_val          = '0;
    endtask

    task automatic ren(input logic [4:0] rd, input logic [31:0] id);
        bus.ID_rename_flag   = 1'b1;
        bus.ID_rename_rd     = rd;
        bus.ID_rename_rob_id = id;
    endtask

    task automatic cmt(input logic [4:0] rd, input logic [31:0] id,
                       input logic [31:0] v);
        bus.cmt_flag   = 1'b1;
        bus.cmt_rd     = rd;
        bus.cmt_rob_id = id;
        bus.cmt_val    = v;
    endtask

    task automatic rd1(input string t, input logic [4:0] rs,
                       input logic b, input logic [31:0] id,
                       input logic [31:0] v);
        bus.ID_rs1 = rs;
        #1;
        chk({t, "_busy1"}, {31'd0, bus.RF_rs1_busy}, {31'd0, b});
        chk({t, "_rob1"}, bus.RF_rs1_rob_id, id);
        chk({t, "_val1"}, bus.RF_rs1_val, v);
    endtask

    task automatic rd2(input string t, input logic [4:0] rs,
                       input logic b, input logic [31:0] id,
                       input logic [31:0] v);
        bus.ID_rs2 = rs;
        #1;
        chk({t, "_busy2"}, {31'd0, bus.RF_rs2_busy}, {31'd0, b});
        chk({t, "_rob2"}, bus.RF_rs2_rob_id, id);
        chk({t, "_val2"}, bus.RF_rs2_val, v);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.ID_rs1 = '0;
        bus.ID_rs2 = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state
        rd1("rst_x5", 5'd5, 1'b0, 32'd0, 32'd0);
        rd2("rst_x31", 5'd31, 1'b0, 32'd0, 32'd0);

        // 2: rename then matching commit
        ren(5'd3, 32'd7);
        tick();
        idle();
        rd1("ren_x3", 5'd3, 1'b1, 32'd7, 32'd0);
        cmt(5'd3, 32'd7, 32'h1234);
`ifdef COMMIT_BYPASS_EN
        rd1("byp_x3", 5'd3, 1'b0, 32'd0, 32'h1234);
`else
        rd1("byp_x3", 5'd3, 1'b1, 32'd7, 32'd0);
`endif
        tick();
        idle();
        rd1("cmt_x3", 5'd3, 1'b0, 32'd0, 32'h1234);

        // 3: older commit must not release younger rename
        ren(5'd3, 32'd7);
        tick();
        ren(5'd3, 32'd9);
        tick();
        idle();
        cmt(5'd3, 32'd7, 32'hAA);
        tick();
        idle();
        rd1("old_cmt", 5'd3, 1'b1, 32'd9, 32'hAA);

        // 4: same-cycle rename and commit on x4
        ren(5'd4, 32'd10);
        tick();
        ren(5'd4, 32'd12);
        cmt(5'd4, 32'd10, 32'hBEEF);
        tick();
        idle();
        rd2("same_x4", 5'd4, 1'b1, 32'd12, 32'hBEEF);

        // full-width tag compare
        ren(5'd7, 32'h8000_0007);
        tick();
        idle();
        cmt(5'd7, 32'h0000_0007, 32'h1);
        tick();
        idle();
        rd2("tagw_x7", 5'd7, 1'b1, 32'h8000_0007, 32'h1);

        // 5: flush with same-cycle commit and rename
        ren(5'd1, 32'd20);
        tick();
        ren(5'd2, 32'd21);
        tick();
        idle();
        bus.jump_wrong_flag = 1'b1;
        cmt(5'd1, 32'd20, 32'h55);
        ren(5'd5, 32'd30);
        tick();
        idle();
        rd1("fl_x1", 5'd1, 1'b0, 32'd0, 32'h55);
        rd2("fl_x2", 5'd2, 1'b0, 32'd0, 32'd0);
        rd1("fl_x3", 5'd3, 1'b0, 32'd0, 32'hAA);
        rd2("fl_x4", 5'd4, 1'b0, 32'd0, 32'hBEEF);
        rd1("fl_x5", 5'd5, 1'b0, 32'd0, 32'd0);

        // 6: x0 is never written or renamed
        cmt(5'd0, 32'd0, 32'hFFFF);
        ren(5'd0, 32'd3);
        tick();
        idle();
        rd1("x0", 5'd0, 1'b0, 32'd0, 32'd0);

        // rdy low freezes state
        rdy = 1'b0;
        ren(5'd6, 32'd40);
        cmt(5'd6, 32'd0, 32'h77);
        tick();
        idle();
        rd2("hold_x6", 5'd6, 1'b0, 32'd0, 32'd0);
        rdy = 1'b1;

        // reset wins even with rdy low
        ren(5'd8, 32'd50);
        tick();
        idle();
        rd1("pre_x8", 5'd8, 1'b1, 32'd50, 32'd0);
        rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        rd1("rst2_x8", 5'd8, 1'b0, 32'd0, 32'd0);
        rd2("rst2_x1", 5'd1, 1'b0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
